// File: rtl/uart_reg_pkg.sv
// Register map, IRQ bit positions and CONFIG layout shared by the UART register file.
package uart_reg_pkg;

  localparam logic [4:0] UART_OPERATION_CONFIG = 5'h00;
  localparam logic [4:0] UART_CMD              = 5'h01;
  localparam logic [4:0] UART_TX_DATA          = 5'h02;
  localparam logic [4:0] UART_RX_DATA          = 5'h03;
  localparam logic [4:0] UART_STATUS           = 5'h04;
  localparam logic [4:0] UART_IRQ_EN           = 5'h05;
  localparam logic [4:0] UART_IRQ_STAT         = 5'h06;
  localparam logic [4:0] UART_ERR_CNT          = 5'h07;

  localparam int IRQ_W          = 4;
  localparam int IRQ_RX_AVAIL   = 0;
  localparam int IRQ_TX_DRAINED = 1;
  localparam int IRQ_RX_OVERRUN = 2;
  localparam int IRQ_TX_OVERFLOW = 3;

  // Bit-exact image of the 32-bit CONFIG register.
  typedef struct packed {
    logic [15:0] clock_divider;
    logic [12:0] rsvd;
    logic        rx_en;
    logic        tx_en;
    logic        crc_en;
  } uart_config_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush; simultaneous push/pop is accepted even when full.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  // Head reads as zero while empty so stale storage never leaks out.
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst_i || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_reg_fifo.sv
// UART register file with TX/RX FIFOs, status and sticky maskable interrupt.
// Define UART_REG_FIFO_ERR_CNT_EN to add the saturating ERR_CNT register at 0x07.
module uart_reg_fifo
  import uart_reg_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              cfg_cs,
  input  logic              cfg_we,
  input  logic [4:0]        cfg_addr_i,
  input  logic [31:0]       cfg_data_i,
  output logic [31:0]       cfg_data_o,
  input  logic              rx_valid_i,
  input  logic [DATA_W-1:0] rx_data_i,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_en_o,
  output logic              rx_en_o,
  output logic              crc_en_o,
  output logic [15:0]       clock_divider_o,
  output logic              irq_o
);

  localparam int TX_CW = $clog2(TX_DEPTH+1);
  localparam int RX_CW = $clog2(RX_DEPTH+1);

  uart_config_t      cfg_q;
  logic [IRQ_W-1:0]  irq_en_q;
  logic [IRQ_W-1:0]  irq_stat_q;
  logic [IRQ_W-1:0]  irq_en_nxt;
  logic [IRQ_W-1:0]  irq_stat_nxt;
  logic [IRQ_W-1:0]  irq_set;
  logic [IRQ_W-1:0]  irq_clr;
  logic [31:0]       err_cnt_rd;

  logic              cfg_rd;
  logic              cfg_wr;
  logic              tx_push, tx_pop, tx_flush, tx_empty, tx_full, tx_drop;
  logic              rx_push, rx_pop, rx_flush, rx_empty, rx_full, rx_drop;
  logic [TX_CW-1:0]  tx_count;
  logic [RX_CW-1:0]  rx_count;
  logic [DATA_W-1:0] rx_head;
  logic              unused_cfg_data;

  assign unused_cfg_data = ^cfg_data_i;

  assign cfg_rd = cfg_cs & ~cfg_we;
  assign cfg_wr = cfg_cs & cfg_we;

  assign tx_en_o         = cfg_q.tx_en;
  assign rx_en_o         = cfg_q.rx_en;
  assign crc_en_o        = cfg_q.crc_en;
  assign clock_divider_o = cfg_q.clock_divider;

  assign tx_push    = cfg_wr & (cfg_addr_i == UART_TX_DATA);
  assign tx_flush   = cfg_wr & (cfg_addr_i == UART_CMD) & cfg_data_i[0];
  assign tx_valid_o = cfg_q.tx_en & ~tx_empty;
  assign tx_pop     = tx_valid_o & tx_ready_i;

  assign rx_push  = rx_valid_i & cfg_q.rx_en;
  assign rx_flush = cfg_wr & (cfg_addr_i == UART_CMD) & cfg_data_i[1];
  assign rx_pop   = cfg_rd & (cfg_addr_i == UART_RX_DATA) & ~rx_empty;

  // A push into a full FIFO survives only if the same cycle pops; flush supersedes both.
  assign tx_drop = tx_push & tx_full & ~tx_pop & ~tx_flush;
  assign rx_drop = rx_push & rx_full & ~rx_pop & ~rx_flush;

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_i (rst_i),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (cfg_data_i[DATA_W-1:0]),
    .dout  (tx_data_o),
    .empty (tx_empty),
    .full  (tx_full),
    .count (tx_count)
  );

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_i (rst_i),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_data_i),
    .dout  (rx_head),
    .empty (rx_empty),
    .full  (rx_full),
    .count (rx_count)
  );

  always_comb begin
    irq_set                  = '0;
    irq_set[IRQ_RX_AVAIL]    = rx_push & ~rx_drop & ~rx_flush;
    irq_set[IRQ_TX_DRAINED]  = tx_pop & ~tx_push & ~tx_flush & (tx_count == TX_CW'(1));
    irq_set[IRQ_RX_OVERRUN]  = rx_drop;
    irq_set[IRQ_TX_OVERFLOW] = tx_drop;
  end

  assign irq_clr      = (cfg_wr && cfg_addr_i == UART_IRQ_STAT) ? cfg_data_i[IRQ_W-1:0] : '0;
  assign irq_stat_nxt = (irq_stat_q & ~irq_clr) | irq_set;
  assign irq_en_nxt   = (cfg_wr && cfg_addr_i == UART_IRQ_EN) ? cfg_data_i[IRQ_W-1:0] : irq_en_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cfg_q      <= '0;
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      irq_o      <= 1'b0;
    end else begin
      if (cfg_wr && cfg_addr_i == UART_OPERATION_CONFIG)
        cfg_q <= uart_config_t'({cfg_data_i[31:16], 13'b0, cfg_data_i[2:0]});
      irq_en_q   <= irq_en_nxt;
      irq_stat_q <= irq_stat_nxt;
      irq_o      <= |(irq_stat_nxt & irq_en_nxt);
    end
  end

`ifdef UART_REG_FIFO_ERR_CNT_EN
  logic [7:0] rx_err_q;
  logic [7:0] tx_err_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic en);
    return (en && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst_i || (cfg_wr && cfg_addr_i == UART_ERR_CNT)) begin
      rx_err_q <= '0;
      tx_err_q <= '0;
    end else begin
      rx_err_q <= sat_inc8(rx_err_q, rx_drop);
      tx_err_q <= sat_inc8(tx_err_q, tx_drop);
    end
  end

  assign err_cnt_rd = {16'b0, tx_err_q, rx_err_q};
`else
  assign err_cnt_rd = '0;
`endif

  always_comb begin
    cfg_data_o = '0;
    if (cfg_rd) begin
      case (cfg_addr_i)
        UART_OPERATION_CONFIG: cfg_data_o = cfg_q;
        UART_RX_DATA:          cfg_data_o = 32'(rx_head);
        UART_STATUS:           cfg_data_o = {8'b0, 8'(rx_count), 8'(tx_count), 4'b0,
                                             rx_full, rx_empty, tx_full, tx_empty};
        UART_IRQ_EN:           cfg_data_o = 32'(irq_en_q);
        UART_IRQ_STAT:         cfg_data_o = 32'(irq_stat_q);
        UART_ERR_CNT:          cfg_data_o = err_cnt_rd;
        default:               cfg_data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_fifo.sv
// Scoreboard bench for uart_reg_fifo: stimulus queues expectations, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_uart_reg_fifo;
  import uart_reg_pkg::*;

  localparam int DATA_W   = 8;
  localparam int TX_DEPTH = 8;
  localparam int RX_DEPTH = 8;
  localparam int K_RD  = 0;
  localparam int K_IRQ = 1;
  localparam int K_TXV = 2;
  localparam int K_TXD = 3;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              cfg_cs, cfg_we;
  logic [4:0]        cfg_addr_i;
  logic [31:0]       cfg_data_i, cfg_data_o;
  logic              rx_valid_i;
  logic [DATA_W-1:0] rx_data_i;
  logic              tx_valid_o, tx_ready_i;
  logic [DATA_W-1:0] tx_data_o;
  logic              tx_en_o, rx_en_o, crc_en_o;
  logic [15:0]       clock_divider_o;
  logic              irq_o;

  logic probe_req = 1'b0;
  logic done      = 1'b0;
  logic checked   = 1'b0;
  int   n_tests   = 0;
  int   n_fail    = 0;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] tx_q[$];
  exp_t              mon_e;
  logic [31:0]       mon_act;
  logic [DATA_W-1:0] mon_tx;

  uart_reg_fifo #(.DATA_W(DATA_W), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .cfg_cs          (cfg_cs),
    .cfg_we          (cfg_we),
    .cfg_addr_i      (cfg_addr_i),
    .cfg_data_i      (cfg_data_i),
    .cfg_data_o      (cfg_data_o),
    .rx_valid_i      (rx_valid_i),
    .rx_data_i       (rx_data_i),
    .tx_valid_o      (tx_valid_o),
    .tx_ready_i      (tx_ready_i),
    .tx_data_o       (tx_data_o),
    .tx_en_o         (tx_en_o),
    .rx_en_o         (rx_en_o),
    .crc_en_o        (crc_en_o),
    .clock_divider_o (clock_divider_o),
    .irq_o           (irq_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((cfg_cs && !cfg_we) || probe_req) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_sample: no expectation queued (rdata=%h)", cfg_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        case (mon_e.kind)
          K_RD:    mon_act = cfg_data_o;
          K_IRQ:   mon_act = {31'b0, irq_o};
          K_TXV:   mon_act = {31'b0, tx_valid_o};
          default: mon_act = 32'(tx_data_o);
        endcase
        if (mon_act !== mon_e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
    if (tx_valid_o && tx_ready_i) begin
      n_tests++;
      if (tx_q.size() == 0) begin
        n_fail++;
        $display("FAIL tx_pop: unexpected pop of %h", tx_data_o);
      end else begin
        mon_tx = tx_q.pop_front();
        if (tx_data_o !== mon_tx) begin
          n_fail++;
          $display("FAIL tx_pop: got %h, expected %h", tx_data_o, mon_tx);
        end
      end
    end
    if (done && !checked) begin
      n_tests++;
      if (exp_q.size() != 0 || tx_q.size() != 0) begin
        n_fail++;
        $display("FAIL leftover: %0d reads and %0d tx bytes never observed, expected 0",
                 exp_q.size(), tx_q.size());
      end
      checked <= 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg_cs = 1'b1; cfg_we = 1'b1; cfg_addr_i = a; cfg_data_i = d;
    cyc();
    cfg_cs = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    push_exp(K_RD, exp, name);
    cfg_cs = 1'b1; cfg_we = 1'b0; cfg_addr_i = a;
    cyc();
    cfg_cs = 1'b0;
  endtask

  task automatic probe(input int kind, input logic [31:0] exp, input string name);
    push_exp(kind, exp, name);
    probe_req = 1'b1;
    cyc();
    probe_req = 1'b0;
  endtask

  task automatic rxc(input logic [DATA_W-1:0] d);
    rx_valid_i = 1'b1; rx_data_i = d;
    cyc();
    rx_valid_i = 1'b0;
  endtask

  task automatic drain_tx(input int limit);
    tx_ready_i = 1'b1;
    for (int i = 0; i < limit && tx_q.size() != 0; i++) cyc();
    tx_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; cfg_cs = 1'b0; cfg_we = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    rx_valid_i = 1'b0; rx_data_i = '0; tx_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    probe(K_IRQ, 0, "rst_irq");
    probe(K_TXV, 0, "rst_tx_valid");
    probe(K_TXD, 0, "rst_tx_data");
    rd(UART_OPERATION_CONFIG, 32'h0, "rst_config");
    rd(UART_STATUS,   32'h5, "rst_status");
    rd(UART_IRQ_STAT, 32'h0, "rst_irq_stat");
    rd(UART_IRQ_EN,   32'h0, "rst_irq_en");
    rd(UART_CMD,      32'h0, "cmd_reads_zero");
    rd(5'h1F,         32'h0, "unmapped_read");
    rd(UART_ERR_CNT,  32'h0, "rst_err_cnt");

    // TX in-order transmission
    wr(UART_OPERATION_CONFIG, 32'h00A3_0002);
    rd(UART_OPERATION_CONFIG, 32'h00A3_0002, "config_rw");
    wr(UART_TX_DATA, 32'h41);
    wr(UART_TX_DATA, 32'h42);
    wr(UART_TX_DATA, 32'h43);
    rd(UART_STATUS, 32'h0000_0304, "tx3_status");
    probe(K_TXD, 32'h41, "tx_head");
    probe(K_TXV, 1, "tx_valid");
    tx_q.push_back(8'h41); tx_q.push_back(8'h42); tx_q.push_back(8'h43);
    drain_tx(20);
    probe(K_TXV, 0, "tx_valid_drained");
    rd(UART_IRQ_STAT, 32'h2, "tx_drained_irq");
    wr(UART_IRQ_STAT, 32'h2);
    rd(UART_IRQ_STAT, 32'h0, "w1c_drained");

    // TX overflow and interrupt
    wr(UART_IRQ_EN, 32'h8);
    for (int i = 0; i < 9; i++) wr(UART_TX_DATA, 32'h50 + 32'(i));
    probe(K_IRQ, 1, "irq_overflow");
    rd(UART_STATUS,   32'h0000_0806, "tx_full_status");
    rd(UART_IRQ_STAT, 32'h8, "tx_overflow_stat");
    wr(UART_IRQ_STAT, 32'h8);
    probe(K_IRQ, 0, "irq_cleared");
    rd(UART_IRQ_STAT, 32'h0, "w1c_overflow");
    for (int i = 0; i < 8; i++) tx_q.push_back(8'h50 + 8'(i));
    drain_tx(40);
    rd(UART_IRQ_STAT, 32'h2, "drained_after_full");
    probe(K_IRQ, 0, "irq_masked");
    wr(UART_IRQ_STAT, 32'h2);
    wr(UART_IRQ_EN, 32'h0);

    // tx_en gating and TX flush
    wr(UART_OPERATION_CONFIG, 32'h0);
    wr(UART_TX_DATA, 32'h66);
    probe(K_TXV, 0, "tx_disabled_valid");
    probe(K_TXD, 32'h66, "tx_disabled_head");
    rd(UART_STATUS, 32'h0000_0104, "tx1_status");
    wr(UART_CMD, 32'h1);
    rd(UART_STATUS, 32'h5, "tx_flush_status");
    probe(K_TXD, 0, "tx_flush_head");

    // RX overrun and ordered readout
    wr(UART_OPERATION_CONFIG, 32'h4);
    for (int i = 0; i < 9; i++) rxc(8'h10 + 8'(i));
    rd(UART_STATUS,   32'h0008_0009, "rx_full_status");
    rd(UART_IRQ_STAT, 32'h5, "rx_overrun_stat");
    for (int i = 0; i < 8; i++) rd(UART_RX_DATA, 32'h10 + 32'(i), "rx_data");
    rd(UART_RX_DATA, 32'h0, "rx_empty_read");
    rd(UART_STATUS,  32'h5, "rx_empty_status");
    wr(UART_IRQ_STAT, 32'hF);
    wr(UART_OPERATION_CONFIG, 32'h0);
    rxc(8'h77);
    rd(UART_STATUS,   32'h5, "rx_disabled_status");
    rd(UART_IRQ_STAT, 32'h0, "rx_disabled_irq");

    // Full RX with simultaneous push and pop
    wr(UART_OPERATION_CONFIG, 32'h4);
    for (int i = 0; i < 8; i++) rxc(8'h20 + 8'(i));
    wr(UART_IRQ_STAT, 32'hF);
    rx_valid_i = 1'b1; rx_data_i = 8'h28;
    rd(UART_RX_DATA, 32'h20, "rx_full_pushpop");
    rx_valid_i = 1'b0;
    rd(UART_IRQ_STAT, 32'h1, "pushpop_no_overrun");
    rd(UART_STATUS,   32'h0008_0009, "pushpop_count");
    for (int i = 1; i < 9; i++) rd(UART_RX_DATA, 32'h20 + 32'(i), "rx_pushpop_order");
    rd(UART_STATUS, 32'h5, "rx_drained_status");

    // Flush with concurrent push, then set-beats-clear
    rxc(8'h31); rxc(8'h32);
    rx_valid_i = 1'b1; rx_data_i = 8'h30;
    wr(UART_CMD, 32'h2);
    rx_valid_i = 1'b0;
    rd(UART_STATUS,  32'h5, "rx_flush_status");
    rd(UART_RX_DATA, 32'h0, "rx_flush_read");
    wr(UART_IRQ_STAT, 32'hF);
    rd(UART_IRQ_STAT, 32'h0, "irq_all_cleared");
    rx_valid_i = 1'b1; rx_data_i = 8'h40;
    wr(UART_IRQ_STAT, 32'h1);
    rx_valid_i = 1'b0;
    rd(UART_IRQ_STAT, 32'h1, "set_beats_clear");
    wr(UART_IRQ_EN, 32'h1);
    probe(K_IRQ, 1, "irq_on_enable");
    wr(UART_IRQ_EN, 32'h0);
    probe(K_IRQ, 0, "irq_on_disable");
    rd(UART_RX_DATA, 32'h40, "rx_after_w1c");

    // Error counters
    for (int i = 0; i < 308; i++) rxc(8'(i));
`ifdef UART_REG_FIFO_ERR_CNT_EN
    rd(UART_ERR_CNT, 32'h0000_01FF, "err_cnt_saturate");
    wr(UART_ERR_CNT, 32'h0);
    rd(UART_ERR_CNT, 32'h0, "err_cnt_clear");
`else
    rd(UART_ERR_CNT, 32'h0, "err_cnt_unmapped");
`endif
    wr(UART_CMD, 32'h2);

    // Reset wins over a concurrent TX push
    wr(UART_OPERATION_CONFIG, 32'h00A3_0002);
    wr(UART_TX_DATA, 32'h99);
    rst_i = 1'b1; cfg_cs = 1'b1; cfg_we = 1'b1; cfg_addr_i = UART_TX_DATA; cfg_data_i = 32'h77;
    cyc();
    rst_i = 1'b0; cfg_cs = 1'b0; cfg_we = 1'b0;
    probe(K_TXV, 0, "rst2_tx_valid");
    probe(K_TXD, 0, "rst2_tx_data");
    probe(K_IRQ, 0, "rst2_irq");
    rd(UART_STATUS, 32'h5, "rst2_status");
    rd(UART_OPERATION_CONFIG, 32'h0, "rst2_config");

    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
